instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory for the single-cycle and pipelined cores.
- Replaces the hard-coded, combinationally read test ROM with a synchronous-read memory.
- After reset, a fill FSM clears every word to NOP. A program-load port then writes the image. Once started, the memory serves fetch requests with 1-cycle latency, stall/flush control and fault flags.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, fill value and bubble value (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- load_we_i  in  1  program-load write strobe.
- load_addr_i  in  32  byte address of the load write.
- load_data_i  in  32  instruction word to write.
- start_i  in  1  leave LOAD and enter RUN.
- load_err_o  out  1  1-cycle pulse: load write rejected.
- load_count_o  out  $clog2(DEPTH)+1  accepted load writes since entering LOAD.
- ready_o  out  1  state == RUN.
- fetch_req_i  in  1  fetch request.
- pc_i  in  32  fetch byte address.
- stall_i  in  1  hold fetch outputs.
- flush_i  in  1  kill in-flight fetch.
- instr_o  out  32  fetched instruction.
- instr_valid_o  out  1  instr_o is valid this cycle.
- misalign_o  out  1  fetch pc_i[1:0] != 0.
- oob_o  out  1  fetch address outside the memory.

Behaviour:
- Reset, while rst_i=1 and on the following edge:
  - state=INIT, fill counter=0.
  - instr_o=NOP_INSTR; instr_valid_o, misalign_o, oob_o, load_err_o, ready_o all 0.
  - load_count_o=0.
  - Reset asserted mid-fill, mid-load or mid-run aborts that activity and restarts INIT.
- INIT:
  - Writes NOP_INSTR to word[fill counter], one word per cycle; counter increments.
  - After word DEPTH-1 is written, goes to LOAD next cycle; INIT lasts exactly DEPTH cycles.
  - load_we_i, start_i and fetch_req_i are ignored; no load_err_o.
- LOAD:
  - Index = (load_addr_i - BASE_ADDR) >> 2.
  - Write is accepted when load_addr_i[1:0]==0 and BASE_ADDR ≤ load_addr_i < BASE_ADDR+4*DEPTH. The word is written at the edge and load_count_o increments, saturating at DEPTH.
  - Otherwise the write is dropped and load_err_o=1 for the next cycle.
  - Rewriting the same address is legal; the last write wins, and the count still increments.
  - start_i=1 moves the FSM to RUN next cycle. A simultaneous valid load_we_i is still accepted.
  - Fetches are ignored in LOAD; instr_valid_o=0.
- RUN:
  - ready_o=1.
  - load_we_i is dropped with a load_err_o pulse; memory is never written in RUN.
  - start_i is ignored.
  - The FSM stays in RUN until reset.
- Fetch, RUN only; registered outputs, latency 1:
  - fetch_req_i=1 at edge N gives the response in cycle N+1.
  - Normal fetch: instr_o=word[index], instr_valid_o=1.
  - pc_i[1:0]!=0: instr_o=NOP_INSTR, instr_valid_o=1, misalign_o=1.
  - Aligned but out of range: instr_o=NOP_INSTR, instr_valid_o=1, oob_o=1. Misalign takes priority, so oob_o=0 in that case.
  - fetch_req_i=0: instr_valid_o=0, flags=0, instr_o=NOP_INSTR.
  - Address arithmetic is 32-bit unsigned. pc_i < BASE_ADDR is out of range, including wrap.
- stall_i=1: all fetch outputs hold their previous values and the request that cycle is discarded. The requester re-presents it.
- flush_i=1: next cycle instr_valid_o=0, instr_o=NOP_INSTR, flags=0.
  - Flush beats stall and beats a concurrent request.
- Memory has a single write source: the fill FSM or the load port, never both in the same cycle.
- Memory contents survive only until the next reset.

Test Plan:
- DEPTH=16, BASE_ADDR=0. Assert rst_i for 2 cycles, release. Required: ready_o=0 for 16 fill cycles. After start_i in RUN, fetching pc=0x3C returns 0x00000013 with valid=1.
- LOAD: write 0x002081B3 at 0x08 and 0x40208233 at 0x0C, then start_i. Fetch 0x08, then 0x0C, on consecutive cycles. Required: load_count_o=2; instr_o=0x002081B3 then 0x40208233, each one cycle after its request.
- LOAD with addresses 0x0A and 0x40. Required: a load_err_o pulse each time, load_count_o unchanged. In RUN, fetch 0x0A gives misalign_o=1 and instr_o=NOP. Fetch 0x40 gives oob_o=1 and instr_o=NOP.
- RUN: fetch 0x08, then stall_i=1 for 3 cycles while pc_i=0x0C. Required: instr_o holds 0x002081B3 with valid=1 throughout. After stall release, 0x0C returns 0x40208233.
- RUN: fetch_req_i=1 with flush_i=1 and stall_i=1 on the same edge. Required: next cycle valid=0, instr_o=NOP.
- In RUN, a load write to 0x08 raises load_err_o and contents stay 0x002081B3. Then assert rst_i mid-RUN. Required: ready_o=0 and the FSM refills; after reload-free start, fetch 0x08 returns NOP.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a power-on NOP fill, a program-load port and a
// synchronous-read fetch port with stall/flush control and fault flags.
module instr_mem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_we_i,
  input  logic [31:0]              load_addr_i,
  input  logic [31:0]              load_data_i,
  input  logic                     start_i,
  output logic                     load_err_o,
  output logic [$clog2(DEPTH):0]   load_count_o,
  output logic                     ready_o,
  input  logic                     fetch_req_i,
  input  logic [31:0]              pc_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [31:0]              instr_o,
  output logic                     instr_valid_o,
  output logic                     misalign_o,
  output logic                     oob_o
);

  localparam int unsigned    AW        = $clog2(DEPTH);
  localparam logic [31:0]    SPAN      = 32'(DEPTH * 4);
  localparam logic [AW:0]    COUNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  FILL_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StInit, StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   fill_q;
  logic [AW:0]     count_q;
  logic            err_q, err_d;
  logic            valid_q, mis_q, oob_q, use_mem_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     load_off, pc_off;
  logic            load_ok, pc_mis, pc_oob;
  logic            mem_we, load_accept;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic            upd, valid_d, mis_d, oob_d, rd_en;

  // Unsigned offset makes addresses below BASE_ADDR wrap to huge values, so
  // a single compare covers both range bounds.
  assign load_off = load_addr_i - BASE_ADDR;
  assign pc_off   = pc_i - BASE_ADDR;
  assign load_ok  = (load_addr_i[1:0] == 2'b00) && (load_off < SPAN);
  assign pc_mis   = (pc_i[1:0] != 2'b00);
  assign pc_oob   = (pc_off >= SPAN);

  always_comb begin
    state_d     = state_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = NOP_INSTR;
    load_accept = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        if (fill_q == FILL_LAST) state_d = StLoad;
      end
      StLoad: begin
        if (load_we_i) begin
          if (load_ok) begin
            mem_we      = 1'b1;
            mem_waddr   = load_off[AW+1:2];
            mem_wdata   = load_data_i;
            load_accept = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start_i) state_d = StRun;
      end
      StRun:   err_d = load_we_i;
      default: state_d = StInit;
    endcase
  end

  // Outputs clear outside RUN; in RUN flush wins, then stall freezes them.
  always_comb begin
    upd     = (state_q != StRun) || flush_i || !stall_i;
    valid_d = (state_q == StRun) && !flush_i && fetch_req_i;
    mis_d   = valid_d && pc_mis;
    oob_d   = valid_d && !pc_mis && pc_oob;
    rd_en   = valid_d && !pc_mis && !pc_oob;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StInit;
      fill_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      oob_q     <= 1'b0;
      use_mem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == StInit) fill_q <= fill_q + 1'b1;
      if (load_accept && (count_q != COUNT_MAX)) count_q <= count_q + 1'b1;
      if (upd) begin
        valid_q   <= valid_d;
        mis_q     <= mis_d;
        oob_q     <= oob_d;
        use_mem_q <= rd_en;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[mem_waddr] <= mem_wdata;
    if (rd_en && upd) rdata_q <= mem[pc_off[AW+1:2]];
  end

  assign instr_o       = use_mem_q ? rdata_q : NOP_INSTR;
  assign instr_valid_o = valid_q;
  assign misalign_o    = mis_q;
  assign oob_o         = oob_q;
  assign load_err_o    = err_q;
  assign load_count_o  = count_q;
  assign ready_o       = (state_q == StRun);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_instr_mem_ctrl;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, load_we, start, fetch_req, stall, flush;
  logic [31:0] load_addr, load_data, pc;
  logic        load_err, ready, instr_valid, misalign, oob;
  logic [4:0]  load_count;
  logic [31:0] instr;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .start_i(start), .load_err_o(load_err),
    .load_count_o(load_count), .ready_o(ready), .fetch_req_i(fetch_req), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .instr_o(instr), .instr_valid_o(instr_valid),
    .misalign_o(misalign), .oob_o(oob)
  );

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = filling, 1 = loading, 2 = running.
  logic [31:0] m_mem [DEPTH];
  int          m_mode, m_fill, m_count;
  logic [31:0] m_instr;
  logic        m_valid, m_mis, m_oob, m_err;

  task automatic m_clear();
    m_instr = NOP; m_valid = 0; m_mis = 0; m_oob = 0;
  endtask

  task automatic model_edge();
    longint off;
    if (rst) begin
      m_mode = 0; m_fill = 0; m_count = 0; m_err = 0;
      m_clear();
      return;
    end
    m_err = 0;
    if (m_mode == 0) begin
      m_mem[m_fill] = NOP;
      m_fill++;
      if (m_fill == DEPTH) m_mode = 1;
      m_clear();
    end else if (m_mode == 1) begin
      if (load_we) begin
        off = longint'(load_addr) - longint'(BASE);
        if (load_addr % 4 == 0 && off >= 0 && off < 4 * DEPTH) begin
          m_mem[off / 4] = load_data;
          if (m_count < DEPTH) m_count++;
        end else m_err = 1;
      end
      if (start) m_mode = 2;
      m_clear();
    end else begin
      m_err = load_we;
      if (flush) m_clear();
      else if (!stall) begin
        if (!fetch_req) m_clear();
        else begin
          off     = longint'(pc) - longint'(BASE);
          m_valid = 1;
          m_mis   = (pc % 4 != 0);
          m_oob   = !m_mis && (off < 0 || off >= 4 * DEPTH);
          m_instr = (m_mis || m_oob) ? NOP : m_mem[off / 4];
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("instr", instr, m_instr);
    chk("valid", 32'(instr_valid), 32'(m_valid));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("oob", 32'(oob), 32'(m_oob));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("load_count", 32'(load_count), 32'(m_count));
    chk("ready", 32'(ready), 32'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {$urandom_range(0, 19), 2'b00};
      1:       return 32'($urandom_range(0, 32'h50));
      2:       return $urandom;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    rst = 1; load_we = 0; start = 0; fetch_req = 0; stall = 0; flush = 0;
    load_addr = 0; load_data = 0; pc = 0;
    step(); step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_instr", instr, NOP);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fill_ready", 32'(ready), 0);
    end

    load_we = 1; load_addr = 32'h08; load_data = 32'h0020_81B3; step();
    chk("load1_count", 32'(load_count), 1);
    load_addr = 32'h0C; load_data = 32'h4020_8233; step();
    chk("load2_count", 32'(load_count), 2);
    load_addr = 32'h0A; step();
    chk("mis_load_err", 32'(load_err), 1);
    chk("mis_load_count", 32'(load_count), 2);
    load_addr = 32'h40; step();
    chk("oob_load_err", 32'(load_err), 1);
    load_we = 0; start = 1; step(); start = 0;
    chk("start_ready", 32'(ready), 1);

    fetch_req = 1; pc = 32'h3C; step();
    chk("f3c_instr", instr, 32'h13);
    chk("f3c_valid", 32'(instr_valid), 1);
    pc = 32'h08; step();
    chk("f08_instr", instr, 32'h0020_81B3);
    pc = 32'h0C; step();
    chk("f0c_instr", instr, 32'h4020_8233);
    pc = 32'h0A; step();
    chk("f0a_mis", 32'(misalign), 1);
    chk("f0a_instr", instr, 32'h13);
    pc = 32'h40; step();
    chk("f40_oob", 32'(oob), 1);
    chk("f40_instr", instr, 32'h13);

    pc = 32'h08; step();
    stall = 1; pc = 32'h0C;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", instr, 32'h0020_81B3);
      chk("stall_valid", 32'(instr_valid), 1);
    end
    stall = 0; step();
    chk("unstall_instr", instr, 32'h4020_8233);

    flush = 1; stall = 1; pc = 32'h08; step();
    chk("flush_valid", 32'(instr_valid), 0);
    chk("flush_instr", instr, 32'h13);
    flush = 0; stall = 0; fetch_req = 0;

    load_we = 1; load_addr = 32'h08; load_data = 32'hDEAD_BEEF; step();
    chk("run_load_err", 32'(load_err), 1);
    load_we = 0; fetch_req = 1; step();
    chk("run_keep_instr", instr, 32'h0020_81B3);
    fetch_req = 0;

    rst = 1; step();
    chk("midrun_rst_ready", 32'(ready), 0);
    rst = 0;
    for (int i = 0; i < 16; i++) step();
    start = 1; step(); start = 0;
    fetch_req = 1; pc = 32'h08; step();
    chk("refill_instr", instr, 32'h13);
    chk("refill_valid", 32'(instr_valid), 1);

    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      load_we   = $urandom_range(0, 1);
      load_addr = rand_addr();
      load_data = $urandom;
      start     = ($urandom_range(0, 79) == 0);
      fetch_req = ($urandom_range(0, 9) < 7);
      pc        = rand_addr();
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
